// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination registers and picks forwarding sources or stalls decode.
// Stage 1 is the youngest tracked instruction; matches are resolved youngest-first.
module hazard_scoreboard #(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_aa,
    input  logic [ADDR_W-1:0] id_ba,
    input  logic              id_ma,
    input  logic              id_mb,
    input  logic              id_rw,
    input  logic [ADDR_W-1:0] id_da,
    input  logic              id_ld,
    input  logic              flush,
    output logic              stall,
    output logic              stall_n,
    output logic [2:0]        fwd_a,
    output logic [2:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic [DEPTH-1:0]             v, rw, ld;
    logic [DEPTH-1:0][ADDR_W-1:0] da;
    logic [2:0]                   sel_a, sel_b;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (id_valid && !id_ma && v[k] && rw[k] && da[k] != '0 && da[k] == id_aa) sel_a = 3'(k + 1);
            if (id_valid && !id_mb && v[k] && rw[k] && da[k] != '0 && da[k] == id_ba) sel_b = 3'(k + 1);
        end
    end

    assign fwd_a   = FWD_EN != 0 ? sel_a : 3'd0;
    assign fwd_b   = FWD_EN != 0 ? sel_b : 3'd0;
    assign stall   = FWD_EN != 0 ? ld[0] && (sel_a == 3'd1 || sel_b == 3'd1)
                                 : (sel_a != 3'd0 || sel_b != 3'd0);
    assign stall_n = ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            v         <= '0;
            rw        <= '0;
            ld        <= '0;
            da        <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush) begin
                v <= '0;
            end else begin
                for (int k = DEPTH - 1; k > 0; k--) begin
                    v[k]  <= v[k-1];
                    rw[k] <= rw[k-1];
                    ld[k] <= ld[k-1];
                    da[k] <= da[k-1];
                end
                v[0]  <= id_valid && !stall;
                rw[0] <= id_rw;
                ld[0] <= id_ld;
                da[0] <= id_da;
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: three configurations share one stimulus stream and are checked
// against an instruction-history model derived from the hazard rules.
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0, id_ma = 1'b1, id_mb = 1'b1, id_rw = 1'b0, id_ld = 1'b0, flush = 1'b0;
    logic [2:0] id_aa = '0, id_ba = '0, id_da = '0;
    logic       st [3];
    logic       stn[3];
    logic [2:0] fa [3];
    logic [2:0] fb [3];
    logic [15:0] cnt0, cnt2;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    hazard_scoreboard #(.ADDR_W(3), .DEPTH(2), .FWD_EN(1), .CNT_W(16)) u_f (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_aa(id_aa), .id_ba(id_ba), .id_ma(id_ma),
        .id_mb(id_mb), .id_rw(id_rw), .id_da(id_da), .id_ld(id_ld), .flush(flush),
        .stall(st[0]), .stall_n(stn[0]), .fwd_a(fa[0]), .fwd_b(fb[0]), .stall_cnt(cnt0));
    hazard_scoreboard #(.ADDR_W(3), .DEPTH(2), .FWD_EN(0), .CNT_W(2)) u_s (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_aa(id_aa), .id_ba(id_ba), .id_ma(id_ma),
        .id_mb(id_mb), .id_rw(id_rw), .id_da(id_da), .id_ld(id_ld), .flush(flush),
        .stall(st[1]), .stall_n(stn[1]), .fwd_a(fa[1]), .fwd_b(fb[1]), .stall_cnt(cnt1));
    hazard_scoreboard #(.ADDR_W(3), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) u_d (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_aa(id_aa), .id_ba(id_ba), .id_ma(id_ma),
        .id_mb(id_mb), .id_rw(id_rw), .id_da(id_da), .id_ld(id_ld), .flush(flush),
        .stall(st[2]), .stall_n(stn[2]), .fwd_a(fa[2]), .fwd_b(fb[2]), .stall_cnt(cnt2));

    typedef struct {bit v; bit rw; bit ld; bit [2:0] da;} ent_t;
    ent_t hist[3][1:7];
    int   dep [3] = '{2, 2, 3};
    int   fen [3] = '{1, 0, 1};
    int   cmax[3] = '{65535, 3, 65535};
    int   mcnt[3] = '{0, 0, 0};
    int   es[3], efa[3], efb[3];
    int   checks = 0, errors = 0;
    bit   known = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(input bit v, input bit [2:0] aa, input bit ma, input bit [2:0] ba, input bit mb,
                          input bit rw, input bit [2:0] da, input bit ld, input bit fl);
        id_valid = v; id_aa = aa; id_ma = ma; id_ba = ba; id_mb = mb;
        id_rw = rw; id_da = da; id_ld = ld; flush = fl;
    endtask

    // Youngest earlier instruction writing a nonzero register that the operand reads.
    function automatic int src(input int c, input bit [2:0] r, input bit off);
        for (int k = 1; k <= dep[c]; k++)
            if (id_valid && !off && hist[c][k].v && hist[c][k].rw && hist[c][k].da != 0 && hist[c][k].da == r)
                return k;
        return 0;
    endfunction

    task automatic look();
        #1;
        for (int c = 0; c < 3; c++) begin
            int sa = src(c, id_aa, id_ma);
            int sb = src(c, id_ba, id_mb);
            if (fen[c] != 0) begin
                efa[c] = sa; efb[c] = sb;
                es[c] = ((sa == 1 || sb == 1) && hist[c][1].ld) ? 1 : 0;
            end else begin
                efa[c] = 0; efb[c] = 0;
                es[c] = (sa != 0 || sb != 0) ? 1 : 0;
            end
        end
        if (known) begin
            for (int c = 0; c < 3; c++) begin
                string n = $sformatf("cfg%0d", c);
                chk({n, "_stall"}, 32'(st[c]), es[c]);
                chk({n, "_stall_n"}, 32'(stn[c]), 32'(es[c] == 0));
                chk({n, "_fwd_a"}, 32'(fa[c]), efa[c]);
                chk({n, "_fwd_b"}, 32'(fb[c]), efb[c]);
            end
            chk("cfg0_cnt", 32'(cnt0), mcnt[0]);
            chk("cfg1_cnt", 32'(cnt1), mcnt[1]);
            chk("cfg2_cnt", 32'(cnt2), mcnt[2]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                mcnt[c] = 0;
                for (int k = 1; k <= 7; k++) hist[c][k] = '{0, 0, 0, 3'd0};
            end else begin
                if (es[c] != 0 && mcnt[c] < cmax[c]) mcnt[c]++;
                if (flush) begin
                    for (int k = 1; k <= 7; k++) hist[c][k].v = 0;
                end else begin
                    for (int k = dep[c]; k >= 2; k--) hist[c][k] = hist[c][k-1];
                    hist[c][1] = '{id_valid && es[c] == 0, id_rw, id_ld, id_da};
                end
            end
        end
        if (rst) known = 1;
        #1;
    endtask

    task automatic step();
        look();
        tick();
    endtask

    initial begin
        // Reset with arbitrary decode inputs
        set_in(1, 3'd5, 0, 3'd5, 0, 1, 3'd5, 1, 0);
        step();
        set_in(1, 3'd2, 0, 3'd3, 0, 1, 3'd2, 0, 0);
        look();
        chk("rst_stall", 32'(st[0]), 0); chk("rst_stall_n", 32'(stn[0]), 1);
        chk("rst_fwd_a", 32'(fa[0]), 0); chk("rst_cnt", 32'(cnt0), 0);
        tick();
        rst = 1'b0;
        // Forwarding from stage 1, then stage 2, then register file
        set_in(1, 3'd0, 1, 3'd0, 1, 1, 3'd5, 0, 0); step();
        set_in(1, 3'd5, 0, 3'd0, 1, 0, 3'd0, 0, 0);
        look(); chk("fwd_s1", 32'(fa[0]), 1); chk("fwd_s1_stall", 32'(st[0]), 0); tick();
        look(); chk("fwd_s2", 32'(fa[0]), 2); tick();
        look(); chk("fwd_rf", 32'(fa[0]), 0); tick();
        // Load-use: one stall then forward from stage 2
        set_in(1, 3'd0, 1, 3'd0, 1, 1, 3'd3, 1, 0); step();
        set_in(1, 3'd0, 1, 3'd3, 0, 0, 3'd0, 0, 0);
        look(); chk("ldu_stall", 32'(st[0]), 1); tick();
        look(); chk("ldu_release", 32'(st[0]), 0); chk("ldu_fwd_b", 32'(fb[0]), 2);
        chk("ldu_cnt", 32'(cnt0), 1); tick();
        // Youngest match, register zero, constant operand
        set_in(1, 3'd0, 1, 3'd0, 1, 1, 3'd4, 0, 0); step(); step();
        set_in(1, 3'd4, 0, 3'd0, 1, 0, 3'd0, 0, 0);
        look(); chk("young_fwd_a", 32'(fa[0]), 1); tick();
        set_in(1, 3'd0, 1, 3'd0, 1, 1, 3'd0, 0, 0); step();
        set_in(1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0);
        look(); chk("r0_fwd_a", 32'(fa[0]), 0); chk("r0_stall", 32'(st[0]), 0); tick();
        set_in(1, 3'd0, 1, 3'd0, 1, 1, 3'd6, 0, 0); step();
        set_in(1, 3'd0, 1, 3'd6, 1, 0, 3'd0, 0, 0);
        look(); chk("mb_fwd_b", 32'(fb[0]), 0); chk("mb_stall_s", 32'(st[1]), 0); tick();
        // Flush during a load-use stall
        set_in(1, 3'd0, 1, 3'd0, 1, 1, 3'd7, 1, 0); step();
        set_in(1, 3'd7, 0, 3'd0, 1, 0, 3'd0, 0, 1);
        look(); chk("flush_stall", 32'(st[0]), 1); tick();
        set_in(1, 3'd7, 0, 3'd0, 1, 0, 3'd0, 0, 0);
        look(); chk("flush_after", 32'(st[0]), 0); chk("flush_fwd_a", 32'(fa[0]), 0); tick();
        // Self-dependency is not a hazard
        set_in(1, 3'd2, 0, 3'd0, 1, 1, 3'd2, 0, 0);
        look(); chk("self_fwd_a", 32'(fa[0]), 0); tick();
        set_in(1, 3'd2, 0, 3'd0, 1, 0, 3'd0, 0, 0); step();
        // Stall-only configuration: two stalls until the entry retires, then saturation
        rst = 1'b1; step(); step(); rst = 1'b0;
        set_in(1, 3'd0, 1, 3'd0, 1, 1, 3'd2, 0, 0); step();
        set_in(1, 3'd2, 0, 3'd0, 1, 0, 3'd0, 0, 0);
        look(); chk("so_stall1", 32'(st[1]), 1); tick();
        look(); chk("so_stall2", 32'(st[1]), 1); tick();
        look(); chk("so_release", 32'(st[1]), 0); chk("so_cnt", 32'(cnt1), 2); tick();
        set_in(1, 3'd0, 1, 3'd0, 1, 1, 3'd2, 0, 0); step();
        set_in(1, 3'd2, 0, 3'd0, 1, 0, 3'd0, 0, 0); step(); step();
        look(); chk("so_sat", 32'(cnt1), 3); tick();
        // Reset while stalled
        set_in(1, 3'd0, 1, 3'd0, 1, 1, 3'd2, 0, 0); step();
        set_in(1, 3'd2, 0, 3'd0, 1, 0, 3'd0, 0, 0);
        look(); chk("rms_stall", 32'(st[1]), 1); tick();
        rst = 1'b1; step(); rst = 1'b0;
        look(); chk("rms_after", 32'(st[1]), 0); chk("rms_cnt", 32'(cnt1), 0); tick();
        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(99) == 0);
            set_in($urandom_range(9) < 8, 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                   1'($urandom), 3'($urandom), $urandom_range(9) < 3, $urandom_range(19) == 0);
            step();
        end
        rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
